// File: rtl/caliptra_fpga_sync_pkg.sv
// Shared types for the FPGA sync block APB sequencer.
// Holds the FSM state encoding and the queued command bundle.
package caliptra_fpga_sync_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_USER_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_seq_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
        logic [2:0]            pprot;
        logic [APB_USER_W-1:0] pauser;
    } apb_cmd_t;

endpackage

// File: rtl/caliptra_fpga_cmd_fifo.sv
// Small synchronous command FIFO feeding the APB sequencer.
// Pointers wrap naturally; the count is one bit wider to tell full from empty.
module caliptra_fpga_cmd_fifo
    import caliptra_fpga_sync_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     aclk_gated,
    input  logic     rstn,
    input  logic     push,
    input  apb_cmd_t push_data,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output apb_cmd_t head
);

    localparam int PW = $clog2(DEPTH);

    apb_cmd_t      mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; push+pop together leaves count alone.
    always_ff @(posedge aclk_gated or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      count <= count + (PW+1)'(1);
            else if (!do_push && do_pop) count <= count - (PW+1)'(1);
        end
    end

    // Storage array; contents are only observed while the entry is valid.
    always_ff @(posedge aclk_gated) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/caliptra_fpga_apb_sequencer.sv
// APB master that drains queued host commands into caliptra_top's APB port.
// One response per transfer; a stuck slave is abandoned after a cycle budget.
module caliptra_fpga_apb_sequencer
    import caliptra_fpga_sync_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int USER_W         = APB_USER_W,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              aclk_gated,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [2:0]        cmd_pprot,
    input  logic [USER_W-1:0] cmd_pauser,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_slverr,
    output logic              resp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic [2:0]        pprot,
    output logic [USER_W-1:0] pauser,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic              busy,
    output logic [15:0]       txn_count
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX =
        TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic TMO_EN = (TIMEOUT_CYCLES != 0);

    apb_seq_state_e state;
    apb_cmd_t       push_cmd;
    apb_cmd_t       head;
    logic           full;
    logic           empty;
    logic [TW-1:0]  tmo_cnt;
    logic           slot_free;
    logic           tmo_hit;
    logic           done;

    assign push_cmd = '{
        write:  cmd_write,
        addr:   cmd_addr,
        wdata:  cmd_wdata,
        pprot:  cmd_pprot,
        pauser: cmd_pauser
    };

    assign cmd_ready = !full;
    assign slot_free = !resp_valid || resp_ready;
    assign tmo_hit   = TMO_EN && !pready && (tmo_cnt == TMAX);
    assign done      = (state == ACCESS) && (pready || tmo_hit);
    assign busy      = (state != IDLE) || !empty;

    caliptra_fpga_cmd_fifo #(
        .DEPTH(CMD_DEPTH)
    ) u_fifo (
        .aclk_gated(aclk_gated),
        .rstn      (rstn),
        .push      (cmd_valid),
        .push_data (push_cmd),
        .pop       (done),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

    // APB phase sequencing plus the single-entry response slot.
    always_ff @(posedge aclk_gated or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            psel         <= 1'b0;
            penable      <= 1'b0;
            pwrite       <= 1'b0;
            paddr        <= '0;
            pwdata       <= '0;
            pprot        <= '0;
            pauser       <= '0;
            tmo_cnt      <= '0;
            txn_count    <= '0;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_slverr  <= 1'b0;
            resp_timeout <= 1'b0;
        end else begin
            // A fresh completion outranks a same-edge ack of the old one.
            if (done) begin
                resp_valid   <= 1'b1;
                resp_rdata   <= (pready && !pwrite) ? prdata : '0;
                resp_slverr  <= pready && pslverr;
                resp_timeout <= !pready;
            end else if (resp_valid && resp_ready) begin
                resp_valid <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (!empty && slot_free) begin
                        state   <= SETUP;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        pwrite  <= head.write;
                        paddr   <= head.addr;
                        pwdata  <= head.wdata;
                        pprot   <= head.pprot;
                        pauser  <= head.pauser;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                end
                ACCESS: begin
                    if (done) begin
                        state     <= IDLE;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        tmo_cnt   <= '0;
                        txn_count <= txn_count + 16'd1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_caliptra_fpga_apb_sequencer.sv
// Directed bench for the APB sequencer: read, waited write, fill/stall,
// timeout, slave error, clock gating and asynchronous reset.
module tb_caliptra_fpga_apb_sequencer;

    logic        aclk;
    logic        gate;
    logic        aclk_gated;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [2:0]  cmd_pprot;
    logic [31:0] cmd_pauser;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_slverr;
    logic        resp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [2:0]  pprot;
    logic [31:0] pauser;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        busy;
    logic [15:0] txn_count;

    int checks   = 0;
    int failures = 0;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    assign aclk_gated = aclk & gate;

    caliptra_fpga_apb_sequencer #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .USER_W        (32),
        .CMD_DEPTH     (4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .aclk_gated  (aclk_gated),
        .rstn        (rstn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_pprot   (cmd_pprot),
        .cmd_pauser  (cmd_pauser),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_slverr (resp_slverr),
        .resp_timeout(resp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pprot       (pprot),
        .pauser      (pauser),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr),
        .busy        (busy),
        .txn_count   (txn_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        gate       = 1'b1;
        rstn       = 1'b0;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = '0;
        cmd_wdata  = '0;
        cmd_pprot  = 3'd0;
        cmd_pauser = '0;
        resp_ready = 1'b0;
        prdata     = '0;
        pready     = 1'b0;
        pslverr    = 1'b0;

        // reset state
        step();
        step();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_txn", txn_count, 0);
        chk("rst_paddr", paddr, 0);
        rstn = 1'b1;
        step();

        // 1: single read, slave ready on first ACCESS
        cmd_valid  = 1'b1;
        cmd_write  = 1'b0;
        cmd_addr   = 32'h3000_0000;
        cmd_pprot  = 3'd2;
        cmd_pauser = 32'hA5A5_0001;
        pready     = 1'b1;
        prdata     = 32'hDEAD_BEEF;
        step();
        cmd_valid = 1'b0;
        chk("t1_e0_psel", psel, 0);
        chk("t1_e0_busy", busy, 1);
        step();
        chk("t1_e1_psel", psel, 1);
        chk("t1_e1_penable", penable, 0);
        chk("t1_e1_paddr", paddr, 32'h3000_0000);
        chk("t1_e1_pwrite", pwrite, 0);
        chk("t1_e1_pprot", pprot, 2);
        chk("t1_e1_pauser", pauser, 32'hA5A5_0001);
        step();
        chk("t1_e2_penable", penable, 1);
        chk("t1_e2_resp_valid", resp_valid, 0);
        step();
        chk("t1_e3_resp_valid", resp_valid, 1);
        chk("t1_e3_rdata", resp_rdata, 32'hDEAD_BEEF);
        chk("t1_e3_slverr", resp_slverr, 0);
        chk("t1_e3_timeout", resp_timeout, 0);
        chk("t1_e3_psel", psel, 0);
        chk("t1_e3_txn", txn_count, 1);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("t1_ack_resp_valid", resp_valid, 0);
        chk("t1_ack_busy", busy, 0);

        // 2: write with three wait states; response left pending
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h3002_0008;
        cmd_wdata = 32'h1234_5678;
        pready    = 1'b0;
        prdata    = 32'hFFFF_FFFF;
        step();
        cmd_valid = 1'b0;
        step();
        chk("t2_setup_psel", psel, 1);
        chk("t2_setup_penable", penable, 0);
        chk("t2_setup_pwdata", pwdata, 32'h1234_5678);
        chk("t2_setup_pwrite", pwrite, 1);
        step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_acc%0d_penable", i), penable, 1);
            chk($sformatf("t2_acc%0d_pwdata", i), pwdata, 32'h1234_5678);
            chk($sformatf("t2_acc%0d_rv", i), resp_valid, 0);
            if (i == 3) pready = 1'b1;
            step();
        end
        chk("t2_done_penable", penable, 0);
        chk("t2_done_psel", psel, 0);
        chk("t2_done_resp_valid", resp_valid, 1);
        chk("t2_done_rdata", resp_rdata, 0);
        chk("t2_done_pwdata_hold", pwdata, 32'h1234_5678);
        chk("t2_done_txn", txn_count, 2);

        // 3: fill the FIFO while the response slot is occupied
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        prdata    = 32'h0000_0011;
        for (int k = 0; k < 4; k++) begin
            cmd_addr = 32'h3001_0000 + 32'(k * 4);
            step();
            chk($sformatf("t3_push%0d_ready", k), cmd_ready, (k < 3) ? 1 : 0);
        end
        cmd_addr = 32'h3001_0010;
        step();
        cmd_valid = 1'b0;
        chk("t3_stall_psel", psel, 0);
        chk("t3_stall_rv", resp_valid, 1);
        chk("t3_full_ready", cmd_ready, 0);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("t3_go_psel", psel, 1);
        chk("t3_go_paddr", paddr, 32'h3001_0000);
        chk("t3_go_rv", resp_valid, 0);
        chk("t3_go_ready", cmd_ready, 0);
        step();
        chk("t3_acc_penable", penable, 1);
        step();
        chk("t3_done_rv", resp_valid, 1);
        chk("t3_done_rdata", resp_rdata, 32'h0000_0011);
        chk("t3_done_ready", cmd_ready, 1);
        chk("t3_done_psel", psel, 0);
        step();
        chk("t3_hold1_psel", psel, 0);
        step();
        chk("t3_hold2_psel", psel, 0);
        chk("t3_hold2_rv", resp_valid, 1);
        resp_ready = 1'b1;
        step();
        for (int k = 1; k < 4; k++) begin
            chk($sformatf("t3_drain%0d_psel", k), psel, 1);
            chk($sformatf("t3_drain%0d_paddr", k), paddr,
                32'h3001_0000 + 32'(k * 4));
            step();
            step();
            step();
        end
        chk("t3_end_busy", busy, 0);
        chk("t3_end_rv", resp_valid, 0);
        chk("t3_end_txn", txn_count, 6);

        // 4: timeout after 8 ACCESS cycles, queued write then proceeds
        pready     = 1'b0;
        prdata     = 32'hFFFF_FFFF;
        cmd_valid  = 1'b1;
        cmd_write  = 1'b0;
        cmd_addr   = 32'h3004_0000;
        step();
        cmd_write = 1'b1;
        cmd_addr  = 32'h3005_0000;
        cmd_wdata = 32'h0000_0055;
        step();
        cmd_valid = 1'b0;
        chk("t4_setup_paddr", paddr, 32'h3004_0000);
        step();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4_acc%0d_psel", i), psel & penable, 1);
            step();
        end
        chk("t4_to_psel", psel, 0);
        chk("t4_to_rv", resp_valid, 1);
        chk("t4_to_timeout", resp_timeout, 1);
        chk("t4_to_rdata", resp_rdata, 0);
        chk("t4_to_slverr", resp_slverr, 0);
        chk("t4_to_txn", txn_count, 7);
        pready = 1'b1;
        step();
        chk("t4_next_psel", psel, 1);
        chk("t4_next_paddr", paddr, 32'h3005_0000);
        chk("t4_next_pwrite", pwrite, 1);
        chk("t4_next_rv", resp_valid, 0);
        step();
        step();
        chk("t4_next_rv_done", resp_valid, 1);
        chk("t4_next_timeout", resp_timeout, 0);
        chk("t4_next_txn", txn_count, 8);
        step();

        // 5: slave error, and push coinciding with pop
        pslverr   = 1'b1;
        prdata    = 32'hCAFE_0000;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h3006_0000;
        step();
        cmd_write = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cmd_addr = 32'h3007_0000 + 32'(k * 4);
            step();
        end
        chk("t5_err_rv", resp_valid, 1);
        chk("t5_err_slverr", resp_slverr, 1);
        chk("t5_err_rdata", resp_rdata, 32'hCAFE_0000);
        chk("t5_pushpop_ready", cmd_ready, 1);
        pslverr  = 1'b0;
        cmd_addr = 32'h3007_000C;
        step();
        cmd_valid = 1'b0;
        chk("t5_full_ready", cmd_ready, 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t5_z%0d_psel", k), psel, 1);
            chk($sformatf("t5_z%0d_paddr", k), paddr,
                32'h3007_0000 + 32'(k * 4));
            step();
            step();
            step();
        end
        chk("t5_end_busy", busy, 0);
        chk("t5_end_slverr", resp_slverr, 0);
        chk("t5_end_txn", txn_count, 13);

        // 6: gate the clock mid-ACCESS, then reset asynchronously
        pready    = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h3008_0000;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("t6_acc_penable", penable, 1);
        @(negedge aclk);
        gate   = 1'b0;
        pready = 1'b1;
        repeat (4) step();
        chk("t6_gated_psel", psel, 1);
        chk("t6_gated_penable", penable, 1);
        chk("t6_gated_rv", resp_valid, 0);
        chk("t6_gated_txn", txn_count, 13);
        rstn = 1'b0;
        #1;
        chk("t6_rst_psel", psel, 0);
        chk("t6_rst_penable", penable, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_txn", txn_count, 0);
        chk("t6_rst_rv", resp_valid, 0);
        chk("t6_rst_ready", cmd_ready, 1);
        @(negedge aclk);
        gate = 1'b1;
        step();
        rstn = 1'b1;
        step();
        prdata    = 32'h0000_0077;
        cmd_valid = 1'b1;
        cmd_addr  = 32'h3009_0000;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        step();
        chk("t6_post_rv", resp_valid, 1);
        chk("t6_post_rdata", resp_rdata, 32'h0000_0077);
        chk("t6_post_txn", txn_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
